sd_linear_interpolator: RTL and testbench

Linear-interpolating upsampler feeding `sigmaDelta2ndOrder`. Accepts signed PCM samples at the low rate through a valid/ready handshake. Emits a new linearly interpolated sample on every `en` tick, spreading each input interval over 2^LOG_RATIO ticks so the modulator input has no zero-order-hold steps. Signals a one-cycle underrun pulse when the source cannot keep up.

---
 rtl/sd_linear_interpolator.sv | 130 +++++++++++++
 tb/tb_sd_linear_interpolator.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_linear_interpolator.sv
// Linear-interpolating upsampler ahead of the 2nd-order sigma-delta modulator.
// Latency: sample accepted at edge t, segment loads at next en tick, out = prev two en-edges later (en=1).
// Backpressure: one-deep buffer; inReady (registered) drops while the buffer holds an unconsumed sample.
//
// Ports:
//   clk, rst      system clock, asynchronous active-low reset
//   en            output-rate tick; everything except the input buffer freezes while low
//   inData        signed input sample (low rate), qualified by inValid / inReady
//   out           signed interpolated sample, one new value per en tick
//   underrun      one-cycle pulse when a segment ends with no buffered sample
module sd_linear_interpolator #(
  parameter int WIDTH     = 16,
  parameter int LOG_RATIO = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] out,
  output logic             underrun
);

  localparam int ACC_W = WIDTH + LOG_RATIO + 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        buf_dat;
  logic                    buf_full, buf_full_nxt;
  logic signed [WIDTH-1:0] prev, prev_nxt;
  logic signed [WIDTH-1:0] target, target_nxt;
  logic signed [WIDTH:0]   delta;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic [LOG_RATIO-1:0]    phase, phase_nxt;
  logic [WIDTH-1:0]        out_nxt;
  logic                    underrun_nxt;
  logic                    xfer;
  logic                    load;

  assign xfer = inValid && inReady;

  // Slope of the current segment. Entering HOLD sets prev = target, which
  // makes the slope zero without a separate delta register to clear.
  assign delta = (WIDTH+1)'(target) - (WIDTH+1)'(prev);

  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev;
    target_nxt   = target;
    acc_nxt      = acc;
    phase_nxt    = phase;
    buf_full_nxt = buf_full;
    out_nxt      = out;
    underrun_nxt = 1'b0;
    load         = 1'b0;

    if (en) begin
      // acc always sits inside [prev, target] scaled by 2^LOG_RATIO, so the
      // bit slice is an exact floor and can never wrap.
      out_nxt = acc[LOG_RATIO +: WIDTH];

      case (state)
        IDLE: load = buf_full;
        RUN: begin
          if (phase == '1) begin
            if (buf_full) begin
              load = 1'b1;
            end else begin
              prev_nxt     = target;
              acc_nxt      = ACC_W'(target) <<< LOG_RATIO;
              underrun_nxt = 1'b1;
              state_nxt    = HOLD;
            end
          end else begin
            acc_nxt   = acc + ACC_W'(delta);
            phase_nxt = phase + 1'b1;
          end
        end
        HOLD:    load = buf_full;
        default: state_nxt = IDLE;
      endcase

      // New segment starts from the old target; target is still 0 in IDLE.
      if (load) begin
        prev_nxt     = target;
        target_nxt   = buf_dat;
        acc_nxt      = ACC_W'(target) <<< LOG_RATIO;
        phase_nxt    = '0;
        buf_full_nxt = 1'b0;
        state_nxt    = RUN;
      end
    end

    // inReady is low whenever buf_full is set, so this never collides with load.
    if (xfer) begin
      buf_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      buf_dat  <= '0;
      buf_full <= 1'b0;
      inReady  <= 1'b0;
      prev     <= '0;
      target   <= '0;
      acc      <= '0;
      phase    <= '0;
      out      <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      buf_full <= buf_full_nxt;
      inReady  <= !buf_full_nxt;
      prev     <= prev_nxt;
      target   <= target_nxt;
      acc      <= acc_nxt;
      phase    <= phase_nxt;
      out      <= out_nxt;
      underrun <= underrun_nxt;
      if (xfer) begin
        buf_dat <= inData;
      end
    end
  end

endmodule

// File: tb/tb_sd_linear_interpolator.sv
// Directed bench for sd_linear_interpolator: sample-level reference model
// plus hand-computed literal expectations for ramps, handshake and reset.
module tb_sd_linear_interpolator;
  localparam int W     = 16;
  localparam int LR    = 5;
  localparam int RATIO = 1 << LR;
  localparam int NLOG  = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         inValid = 1'b0;
  logic [W-1:0] inData = '0;
  logic         inReady;
  logic [W-1:0] out;
  logic         underrun;

  sd_linear_interpolator #(.WIDTH(W), .LOG_RATIO(LR)) dut (
    .clk(clk), .rst(rst), .en(en),
    .inData(inData), .inValid(inValid), .inReady(inReady),
    .out(out), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int en_div = 1;
  int n_acc = 0;
  int last_acc = 0;
  int acc_cyc[$];
  int src_q[$];
  int out_log[NLOG];
  bit unr_log[NLOG];
  int last_out = 0;
  bit last_en = 1'b0;

  // Reference model: segment endpoints and position within the segment.
  int m_mode, m_buf, m_prev, m_tgt, m_ph, m_out;
  bit m_full, m_rdy, m_unr;

  // scratch
  int s, e, t, hi, lo, mx, mn, bad, k, a5;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int fdiv(input int a);
    return (a >= 0) ? a / RATIO : -((-a + RATIO - 1) / RATIO);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_buf = 0; m_prev = 0; m_tgt = 0; m_ph = 0; m_out = 0;
    m_full = 1'b0; m_rdy = 1'b0; m_unr = 1'b0;
  endtask

  // Called at each clk edge with the inputs as they were at that edge.
  task automatic model_step();
    bit xf;
    if (!rst) begin
      model_reset();
      return;
    end
    xf = inValid && m_rdy;
    m_unr = 1'b0;
    if (en) begin
      case (m_mode)
        0:       m_out = 0;
        1:       m_out = fdiv(m_prev * RATIO + (m_tgt - m_prev) * m_ph);
        default: m_out = m_tgt;
      endcase
      if (m_mode == 1 && m_ph < RATIO - 1) begin
        m_ph++;
      end else if (m_full) begin
        m_prev = m_tgt; m_tgt = m_buf; m_ph = 0; m_full = 1'b0; m_mode = 1;
      end else if (m_mode == 1) begin
        m_mode = 2; m_unr = 1'b1;
      end
    end
    if (xf) begin
      m_full = 1'b1;
      m_buf = int'($signed(inData));
    end
    m_rdy = !m_full;
  endtask

  task automatic present();
    if (src_q.size() > 0) begin
      inValid = 1'b1;
      inData = W'(src_q[0]);
    end else begin
      inValid = 1'b0;
    end
  endtask

  // One clock: compare at negedge, step model at posedge, drive inputs at posedge+1.
  task automatic tick();
    bit rdy_s, vld_s;
    @(negedge clk);
    if (!rst) begin
      check("reset_out", int'($signed(out)), 0);
      check("reset_inReady", int'(inReady), 0);
      check("reset_underrun", int'(underrun), 0);
    end else begin
      check("out", int'($signed(out)), m_out);
      check("inReady", int'(inReady), int'(m_rdy));
      check("underrun", int'(underrun), int'(m_unr));
      if (int'($signed(out)) != last_out) check("out_moves_only_on_en", int'(last_en), 1);
    end
    if (cyc < NLOG) begin
      out_log[cyc] = int'($signed(out));
      unr_log[cyc] = underrun;
    end
    last_out = int'($signed(out));
    last_en = en;
    rdy_s = inReady;
    vld_s = inValid;
    @(posedge clk);
    cyc++;
    model_step();
    if (rst && vld_s && rdy_s) begin
      n_acc++;
      last_acc = cyc;
      acc_cyc.push_back(cyc);
      void'(src_q.pop_front());
    end
    #1;
    en = (cyc % en_div == 0);
    present();
  endtask

  task automatic wait_acc(input int n, input string name);
    int kk;
    kk = 0;
    while (n_acc < n && kk < 600) begin
      tick();
      kk++;
    end
    check(name, int'(n_acc >= n), 1);
  endtask

  task automatic run_to(input int c);
    while (cyc <= c && cyc < NLOG - 2) tick();
  endtask

  function automatic int count_unr(input int a, input int b);
    int n;
    n = 0;
    for (int i = a; i <= b; i++) if (i >= 0 && i < NLOG) n += int'(unr_log[i]);
    return n;
  endfunction

  function automatic int log_at(input int i);
    return (i >= 0 && i < NLOG) ? out_log[i] : 99999;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    src_q.delete();
    inValid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // Single sample 16384 from IDLE: 0, 512, ... 15872 then 16384 held.
  task automatic ramp_test(input string tag);
    int ta;
    n_acc = 0;
    src_q.push_back(16384);
    present();
    wait_acc(1, {tag, "_accept"});
    ta = last_acc;
    run_to(ta + 40);
    check({tag, "_t2"}, log_at(ta + 2), 0);
    check({tag, "_t3"}, log_at(ta + 3), 512);
    check({tag, "_t33"}, log_at(ta + 33), 15872);
    check({tag, "_t34"}, log_at(ta + 34), 16384);
    check({tag, "_t40"}, log_at(ta + 40), 16384);
    check({tag, "_unr_at_wrap"}, int'(unr_log[ta + 33]), 1);
    check({tag, "_unr_count"}, count_unr(ta, ta + 40), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    model_reset();
    #1 rst = 1'b0;
    src_q.push_back(1234);
    present();
    #1;
    check("async_reset_out", int'($signed(out)), 0);
    check("async_reset_inReady", int'(inReady), 0);
    check("async_reset_underrun", int'(underrun), 0);
    repeat (4) tick();
    check("reset_no_transfer", n_acc, 0);
    src_q.delete();
    inValid = 1'b0;
    rst = 1'b1;
    check("ready_low_at_release", int'(inReady), 0);
    tick();
    check("ready_after_one_edge", int'(inReady), 1);

    // Single sample ramp from IDLE.
    ramp_test("idle_ramp");

    // Full-scale stream: 0 -> 32767 -> -32768 -> -32768.
    do_reset();
    n_acc = 0;
    src_q = '{32767, -32768, -32768};
    present();
    s = cyc;
    run_to(s + 100);
    e = s + 100;
    hi = -1; lo = -1; mx = -99999; mn = 99999; bad = 0;
    for (int i = s; i <= e; i++) begin
      if (out_log[i] > mx) mx = out_log[i];
      if (out_log[i] < mn) mn = out_log[i];
      if (hi < 0 && out_log[i] == 32767) hi = i;
      if (lo < 0 && out_log[i] == -32768) lo = i;
    end
    if (hi < 0) hi = s;
    if (lo < hi) lo = e;
    for (int i = hi; i < lo; i++) if (out_log[i + 1] > out_log[i]) bad++;
    check("stream_max", mx, 32767);
    check("stream_min", mn, -32768);
    check("stream_first_fall", log_at(hi + 1), 30719);
    check("stream_last_before_min", log_at(lo - 1), -30721);
    check("stream_segment_span", lo - hi, 32);
    check("stream_monotonic_violations", bad, 0);
    check("stream_no_underrun", count_unr(s, lo), 0);

    // en at 1/4 duty with a continuous stream.
    en_div = 4;
    n_acc = 0;
    acc_cyc.delete();
    src_q = '{1000, -2000, 3000, 500};
    present();
    wait_acc(4, "quarter_accepts");
    if (acc_cyc.size() >= 4) begin
      check("quarter_span_a", acc_cyc[2] - acc_cyc[1], 4 * RATIO);
      check("quarter_span_b", acc_cyc[3] - acc_cyc[2], 4 * RATIO);
    end
    run_to(cyc + 20);

    // Backpressure then stall.
    en_div = 1;
    do_reset();
    n_acc = 0;
    acc_cyc.delete();
    src_q = '{100, 200, 300, 400, 500};
    present();
    wait_acc(5, "bp_accepts");
    a5 = last_acc;
    if (acc_cyc.size() >= 5) begin
      check("bp_span_a", acc_cyc[2] - acc_cyc[1], RATIO);
      check("bp_span_b", acc_cyc[3] - acc_cyc[2], RATIO);
      check("bp_span_c", acc_cyc[4] - acc_cyc[3], RATIO);
      check("bp_no_underrun", count_unr(acc_cyc[0], a5 + 20), 0);
    end
    run_to(a5 + 110);
    check("stall_one_underrun", count_unr(a5 + 21, a5 + 110), 1);
    check("stall_holds_last", log_at(a5 + 110), 500);
    n_acc = 0;
    src_q.push_back(1780);
    present();
    wait_acc(1, "resume_accept");
    t = last_acc;
    run_to(t + 4);
    check("resume_t1", log_at(t + 1), 500);
    check("resume_t2", log_at(t + 2), 500);
    check("resume_t3", log_at(t + 3), 540);
    check("resume_t4", log_at(t + 4), 580);

    // Reset mid-ramp at out = 8000.
    do_reset();
    n_acc = 0;
    src_q.push_back(16000);
    present();
    k = 0;
    while (int'($signed(out)) != 8000 && k < 100) begin
      tick();
      k++;
    end
    check("midramp_reached", int'($signed(out)), 8000);
    rst = 1'b0;
    #1;
    check("midramp_async_out", int'($signed(out)), 0);
    check("midramp_async_inReady", int'(inReady), 0);
    check("midramp_async_underrun", int'(underrun), 0);
    src_q.delete();
    inValid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    ramp_test("post_reset_ramp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
